// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Multi-cycle shift sequencer built around one 1-bit shift stage. It accepts
//   a request of operand, count and op. It then shifts one bit per clock and
//   pulses done for one cycle when the result in out is final. This is the
//   small-area alternative to a barrel shifter; the requester stalls on busy.
// Ports
//   clk    system clock, rising edge
//   rst    synchronous reset, active high
//   start  request strobe, only honoured while ready=1
//   in     operand, captured on an accepted start
//   cnt    shift amount 0..WIDTH-1, captured on an accepted start
//   op     00=ROL 01=SLL 10=ROR 11=SRL, captured on an accepted start
//   ready  high in IDLE
//   busy   high in SHIFT and DONE
//   done   one-cycle completion pulse
//   out    working/result register; holds the result until the next start
module shift_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4   // 2**CNTW must equal WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [CNTW-1:0]  cnt,
  input  logic [1:0]       op,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [CNTW-1:0]   rem_q, rem_d;
  logic [1:0]        op_q, op_d;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic [1:0] o);
    case (o)
      OP_ROL:  shift1 = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_SLL:  shift1 = {v[WIDTH-2:0], 1'b0};
      OP_ROR:  shift1 = {v[0], v[WIDTH-1:1]};
      default: shift1 = {1'b0, v[WIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          out_d   = in;
          rem_d   = cnt;
          op_d    = op;
          // A zero count skips SHIFT, so SHIFT never runs with rem_q==0.
          state_d = (cnt != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        out_d = shift1(out_q, op_q);
        rem_d = rem_q - 1'b1;
        if (rem_q == CNTW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  // Moore outputs: decoded from the registered state only.
  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
  assign out   = out_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] in, out;
  logic [3:0]  cnt;
  logic [1:0]  op;
  logic        ready, busy, done;
  int checks = 0;
  int failures = 0;

  shift_seq_ctrl #(.WIDTH(16), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in), .cnt(cnt), .op(op),
    .ready(ready), .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic r, input logic b, input logic d);
    chk({tag, "_ready"}, {31'd0, ready}, {31'd0, r});
    chk({tag, "_busy"},  {31'd0, busy},  {31'd0, b});
    chk({tag, "_done"},  {31'd0, done},  {31'd0, d});
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; in = 16'hAAAA; cnt = 4'd3; op = 2'b01;
    tick(); tick();
    // T1 reset with start held high
    chk("t1_out", {16'd0, out}, 32'h0);
    chk_flags("t1", 1'b1, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("t1_idle_out", {16'd0, out}, 32'h0);
    chk_flags("t1_idle", 1'b1, 1'b0, 1'b0);

    // T2 SLL 0x0001 by 4 -> 0x0010, done 5 cycles after the start cycle
    in = 16'h0001; cnt = 4'd4; op = 2'b01; start = 1'b1;
    tick();
    start = 1'b0; in = 16'h5555; cnt = 4'd9; op = 2'b11;
    chk_flags("t2_c1", 1'b0, 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("t2_nodone", {31'd0, done}, 32'd0);
    end
    tick();
    chk_flags("t2_c5", 1'b0, 1'b1, 1'b1);
    chk("t2_out", {16'd0, out}, 32'h0010);
    tick();
    chk_flags("t2_after", 1'b1, 1'b0, 1'b0);
    chk("t2_hold", {16'd0, out}, 32'h0010);

    // T3 ROL 0x8001 by 1 -> 0x0003, then ROR 0x0001 by 1 -> 0x8000
    in = 16'h8001; cnt = 4'd1; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_rol_c1_done", {31'd0, done}, 32'd0);
    tick();
    chk("t3_rol_done", {31'd0, done}, 32'd1);
    chk("t3_rol_out", {16'd0, out}, 32'h0003);
    tick();
    in = 16'h0001; cnt = 4'd1; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t3_ror_done", {31'd0, done}, 32'd1);
    chk("t3_ror_out", {16'd0, out}, 32'h8000);
    tick();

    // T4 zero count goes straight to DONE
    in = 16'hBEEF; cnt = 4'd0; op = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    chk_flags("t4_c1", 1'b0, 1'b1, 1'b1);
    chk("t4_out", {16'd0, out}, 32'hBEEF);
    tick();
    chk_flags("t4_c2", 1'b1, 1'b0, 1'b0);
    chk("t4_hold", {16'd0, out}, 32'hBEEF);

    // T5 SRL 0x8000 by 15 with an ignored start during SHIFT
    in = 16'h8000; cnt = 4'd15; op = 2'b11; start = 1'b1;
    tick();
    start = 1'b1; in = 16'h1234; cnt = 4'd2; op = 2'b00;
    tick();
    start = 1'b0;
    chk("t5_c2_out", {16'd0, out}, 32'h4000);
    for (int i = 3; i <= 15; i++) begin
      tick();
      chk("t5_nodone", {31'd0, done}, 32'd0);
    end
    tick();
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_out", {16'd0, out}, 32'h0001);
    tick();
    chk_flags("t5_after", 1'b1, 1'b0, 1'b0);
    chk("t5_hold", {16'd0, out}, 32'h0001);

    // T6 reset in the 3rd SHIFT cycle, then a fresh request
    in = 16'hFFFF; cnt = 4'd8; op = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_c2_out", {16'd0, out}, 32'hFFFE);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_out", {16'd0, out}, 32'h0);
    chk_flags("t6_rst", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_nodone", {31'd0, done}, 32'd0);
    end
    in = 16'h0003; cnt = 4'd2; op = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_new_nodone", {31'd0, done}, 32'd0);
    tick();
    chk("t6_new_done", {31'd0, done}, 32'd1);
    chk("t6_new_out", {16'd0, out}, 32'h000C);
    tick();
    chk_flags("t6_new_after", 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
